// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: blanking-first h/v counters, sync/active
// decode, and a DELAY-deep output pipeline that advances only on pixel enable.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 128,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 9,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 28,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CW         = 10,
  parameter int DELAY      = 1,
  parameter int CELL_SHIFT = 0,
  parameter int FCW        = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           ce,
  output logic           hsync,
  output logic           vsync,
  output logic           activevideo,
  output logic [CW-1:0]  x_px,
  output logic [CW-1:0]  y_px,
  output logic [CW-1:0]  x_cell,
  output logic [CW-1:0]  y_cell,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int HT      = H_BLANK + H_ACTIVE;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int VT      = V_BLANK + V_ACTIVE;

  if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1 ||
      H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0 ||
      DELAY < 1 || DELAY > 4 || CELL_SHIFT < 0 || FCW < 1 ||
      HT > (1 << CW) || VT > (1 << CW)) begin : g_param_err
    $error("vga_timing_gen: illegal parameter set");
  end

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          av;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
  } stg_t;

  logic [CW-1:0]  hc_q, hc_d, vc_q, vc_d;
  logic [FCW-1:0] fc_q, fc_d;
  stg_t [DELAY-1:0] pipe_q;
  stg_t s0, idle;

  always_comb begin
    hc_d = hc_q + CW'(1);
    vc_d = vc_q;
    fc_d = fc_q;
    if (hc_q == CW'(HT - 1)) begin
      hc_d = '0;
      if (vc_q == CW'(VT - 1)) begin
        vc_d = '0;
        fc_d = fc_q + FCW'(1);
      end else begin
        vc_d = vc_q + CW'(1);
      end
    end
  end

  // Stage-0 decode straight from the counters; everything below is registered.
  always_comb begin
    s0    = '0;
    s0.hs = ((hc_q >= CW'(H_FP)) && (hc_q < CW'(H_FP + H_SYNC))) ? HS_POL : ~HS_POL;
    s0.vs = ((vc_q >= CW'(V_FP)) && (vc_q < CW'(V_FP + V_SYNC))) ? VS_POL : ~VS_POL;
    s0.av = (hc_q >= CW'(H_BLANK)) && (vc_q >= CW'(V_BLANK));
    s0.x  = s0.av ? hc_q - CW'(H_BLANK) : '0;
    s0.y  = s0.av ? vc_q - CW'(V_BLANK) : '0;
    s0.ls = (hc_q == CW'(H_BLANK)) && (vc_q >= CW'(V_BLANK));
    s0.fs = (hc_q == '0) && (vc_q == '0);
  end

  always_comb begin
    idle    = '0;
    idle.hs = ~HS_POL;
    idle.vs = ~VS_POL;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hc_q <= '0;
      vc_q <= '0;
      fc_q <= '0;
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= idle;
    end else if (ce) begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      fc_q <= fc_d;
      pipe_q[0] <= s0;
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign hsync       = pipe_q[DELAY-1].hs;
  assign vsync       = pipe_q[DELAY-1].vs;
  assign activevideo = pipe_q[DELAY-1].av;
  assign x_px        = pipe_q[DELAY-1].x;
  assign y_px        = pipe_q[DELAY-1].y;
  // Cells come from the same final stage so they never skew against x/y.
  assign x_cell      = pipe_q[DELAY-1].x >> CELL_SHIFT;
  assign y_cell      = pipe_q[DELAY-1].y >> CELL_SHIFT;
  assign line_start  = pipe_q[DELAY-1].ls;
  assign frame_start = pipe_q[DELAY-1].fs;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-mode checkpoint table plus a queue-based reference model for a
// tiny mode (DELAY=3 and DELAY=1/inverted polarity) under random ce and resets.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs, vs, av;
    logic [9:0] x, y, xc, yc;
    logic       ls, fs;
  } outs_t;

  typedef struct {
    int e;
    bit hs, vs, av;
    int x, y;
    bit ls, fs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- default-mode instance ----------------
  logic rst0 = 1'b0, ce0 = 1'b1;
  logic hs0, vs0, av0, ls0, fs0;
  logic [9:0] x0, y0, xc0, yc0;
  logic [7:0] fc0;
  outs_t a0;
  assign a0 = {hs0, vs0, av0, x0, y0, xc0, yc0, ls0, fs0};

  vga_timing_gen u0 (
    .clk(clk), .resetn(rst0), .ce(ce0), .hsync(hs0), .vsync(vs0),
    .activevideo(av0), .x_px(x0), .y_px(y0), .x_cell(xc0), .y_cell(yc0),
    .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0));

  // ---------------- small-mode instances ----------------
  logic rst1 = 1'b0, ce1 = 1'b0;
  logic hs1, vs1, av1, ls1, fs1, hs2, vs2, av2, ls2, fs2;
  logic [9:0] x1, y1, xc1, yc1, x2, y2, xc2, yc2;
  logic [1:0] fc1, fc2;
  outs_t a1, a2;
  assign a1 = {hs1, vs1, av1, x1, y1, xc1, yc1, ls1, fs1};
  assign a2 = {hs2, vs2, av2, x2, y2, xc2, yc2, ls2, fs2};

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .DELAY(3), .CELL_SHIFT(1), .FCW(2)) u1 (
    .clk(clk), .resetn(rst1), .ce(ce1), .hsync(hs1), .vsync(vs1),
    .activevideo(av1), .x_px(x1), .y_px(y1), .x_cell(xc1), .y_cell(yc1),
    .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .DELAY(1), .CELL_SHIFT(1), .FCW(2)) u2 (
    .clk(clk), .resetn(rst1), .ce(ce1), .hsync(hs2), .vsync(vs2),
    .activevideo(av2), .x_px(x2), .y_px(y2), .x_cell(xc2), .y_cell(yc2),
    .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference for the small mode: HT=7 (blank 3), VT=5 (blank 3), cells = px>>1.
  function automatic outs_t mdl(input int hc, input int vc, input bit hp, input bit vp);
    outs_t o;
    o.hs = (hc == 1) ? hp : ~hp;
    o.vs = (vc == 1) ? vp : ~vp;
    o.av = (hc >= 3) && (vc >= 3);
    o.x  = o.av ? 10'(hc - 3) : 10'd0;
    o.y  = o.av ? 10'(vc - 3) : 10'd0;
    o.xc = o.x >> 1;
    o.yc = o.y >> 1;
    o.ls = (hc == 3) && (vc >= 3);
    o.fs = (hc == 0) && (vc == 0);
    return o;
  endfunction

  function automatic outs_t idle(input bit hp, input bit vp);
    outs_t o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    return o;
  endfunction

  outs_t q1[$], q2[$];
  outs_t exp1, exp2;
  int mhc = 0, mvc = 0, mfc = 0;

  task automatic step(input bit c, input bit r);
    ce1 = c;
    rst1 = r;
    @(posedge clk);
    if (!r) begin
      mhc = 0; mvc = 0; mfc = 0;
      q1.delete(); q2.delete();
      repeat (2) q1.push_back(idle(1'b0, 1'b0));
      exp1 = idle(1'b0, 1'b0);
      exp2 = idle(1'b1, 1'b1);
    end else if (c) begin
      q1.push_back(mdl(mhc, mvc, 1'b0, 1'b0));
      q2.push_back(mdl(mhc, mvc, 1'b1, 1'b1));
      exp1 = q1.pop_front();
      exp2 = q2.pop_front();
      if (mhc == 6) begin
        mhc = 0;
        if (mvc == 4) begin mvc = 0; mfc = (mfc + 1) % 4; end
        else mvc++;
      end else mhc++;
    end
    #1;
    chk("small_d3", 64'(a1), 64'(exp1));
    chk("small_d1_pol", 64'(a2), 64'(exp2));
    chk("fcnt_d3", 64'(fc1), 64'(mfc));
    chk("fcnt_d1", 64'(fc2), 64'(mfc));
  endtask

  vec_t tbl[16];

  initial begin
    //          edge    hs vs av  x  y ls fs
    tbl[0]  = '{0,      1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1,      1, 1, 0, 0, 0, 0, 1};
    tbl[2]  = '{2,      1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{24,     1, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{25,     0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{64,     0, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{65,     1, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{833,    1, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{857,    0, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{7488,   1, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{7489,   1, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{9985,   1, 1, 0, 0, 0, 0, 0};
    tbl[12] = '{33472,  1, 1, 0, 0, 0, 0, 0};
    tbl[13] = '{33473,  1, 1, 1, 0, 0, 1, 0};
    tbl[14] = '{33474,  1, 1, 1, 1, 0, 0, 0};
    tbl[15] = '{34305,  1, 1, 1, 0, 1, 1, 0};

    fork
      begin : p_default
        int e;
        outs_t ex;
        rst0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst0 = 1'b1;
        e = 0;
        foreach (tbl[i]) begin
          while (e < tbl[i].e) begin
            @(posedge clk);
            e++;
          end
          #1;
          ex = {tbl[i].hs, tbl[i].vs, tbl[i].av, 10'(tbl[i].x), 10'(tbl[i].y),
                10'(tbl[i].x), 10'(tbl[i].y), tbl[i].ls, tbl[i].fs};
          chk($sformatf("default_edge%0d", tbl[i].e), 64'(a0), 64'(ex));
        end
        chk("default_fcnt", 64'(fc0), 64'd0);
      end
      begin : p_small
        int guard;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (105) step(1'b1, 1'b1);
        repeat (300) step(1'($urandom_range(0, 1)), 1'b1);
        guard = 0;
        while (!(mhc == 3 && mvc == 3) && guard < 200) begin
          step(1'b1, 1'b1);
          guard++;
        end
        chk("reach_midline", 64'(guard < 200), 64'd1);
        step(1'b1, 1'b0);
        chk("rst_fcnt", 64'(fc1), 64'd0);
        repeat (3) step(1'b1, 1'b1);
        chk("fs_after_rst", 64'(fs1), 64'd1);
        repeat (3) step(1'b0, 1'b1);
        chk("fs_held_gap", 64'(fs1), 64'd1);
        step(1'b1, 1'b1);
        chk("fs_single", 64'(fs1), 64'd0);
        repeat (80) step(1'b1, 1'b1);
        repeat (150) step(1'($urandom_range(0, 1)), 1'b1);
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
